// File: rtl/cia_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : cia_pkg
// Description : Shared constants and types for the CIA serial port slice:
//               SDR width, CRA bit indices, serial FSM states and register
//               offsets of the blocks that sit next to the serial port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package cia_pkg;

  localparam int SDR_BITS = 8;

  // Control register A bit positions
  localparam int CRA_START   = 0;
  localparam int CRA_RUNMODE = 3;
  localparam int CRA_LOAD    = 4;
  localparam int CRA_SPMODE  = 6;

  // Register offsets within the CIA address map
  localparam logic [3:0] REG_TALO = 4'h4;
  localparam logic [3:0] REG_TAHI = 4'h5;
  localparam logic [3:0] REG_SDR  = 4'hC;
  localparam logic [3:0] REG_CRA  = 4'hE;

  // Output-mode shifter states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sp_state_e;

endpackage : cia_pkg
`default_nettype wire

// File: rtl/cia_pin_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : cia_pin_sync
// Description : Multi-stage synchroniser for an asynchronous pin followed by
//               a rising-edge detector on the synchronised level. Flops reset
//               to the pin's idle level so no false edge follows reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module cia_pin_sync #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clk7_en,
  input  logic pin,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the synchroniser chain and keep the last level
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{IDLE_LEVEL}};
      prev  <= IDLE_LEVEL;
    end else if (clk7_en) begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;

endmodule : cia_pin_sync
`default_nettype wire

// File: rtl/cia_serialport.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : cia_serialport
// Description : CIA serial data register and 8-bit shifter. In output mode
//               Timer A underflows clock bytes out MSB first on CNT/SP; in
//               input mode bytes are sampled on synchronised CNT rising edges.
//               A one-cycle irq pulse marks every completed byte.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module cia_serialport
  import cia_pkg::*;
#(
  parameter int BITS        = SDR_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk7_en,
  input  logic            wr,
  input  logic            sdr,
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] data_out,
  input  logic            tmra_ovf,
  input  logic            spmode,
  input  logic            cnt_in,
  input  logic            sp_in,
  output logic            cnt_out,
  output logic            sp_out,
  output logic            irq
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

  sp_state_e       state,   state_nx;
  logic [BITS-1:0] sdr_reg, sdr_reg_nx;
  logic [BITS-1:0] shifter, shifter_nx;
  logic [CW-1:0]   bitcnt,  bitcnt_nx;
  logic            pending, pending_nx;
  logic            cnt_q,   cnt_nx;
  logic            sp_q,    sp_nx;
  logic            irq_q,   irq_nx;
  logic            spmode_q;

  logic            cnt_sync;
  logic            cnt_rise;
  logic            sp_sync;
  logic            sp_rise_unused;
  logic            sdr_write;
  logic            mode_change;
  logic [BITS-1:0] shifted_in;

  cia_pin_sync #(
    .STAGES     (SYNC_STAGES),
    .IDLE_LEVEL (1'b1)
  ) u_cnt_sync (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .pin     (cnt_in),
    .sync    (cnt_sync),
    .rise    (cnt_rise)
  );

  cia_pin_sync #(
    .STAGES     (SYNC_STAGES),
    .IDLE_LEVEL (1'b1)
  ) u_sp_sync (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .pin     (sp_in),
    .sync    (sp_sync),
    .rise    (sp_rise_unused)
  );

  assign sdr_write   = wr & sdr;
  assign mode_change = (spmode != spmode_q);
  assign shifted_in  = {shifter[BITS-2:0], sp_sync};

  // State register for the FSM and the whole serial datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sdr_reg  <= '0;
      shifter  <= '0;
      bitcnt   <= '0;
      pending  <= 1'b0;
      cnt_q    <= 1'b1;
      sp_q     <= 1'b1;
      irq_q    <= 1'b0;
      spmode_q <= 1'b0;
    end else if (clk7_en) begin
      state    <= state_nx;
      sdr_reg  <= sdr_reg_nx;
      shifter  <= shifter_nx;
      bitcnt   <= bitcnt_nx;
      pending  <= pending_nx;
      cnt_q    <= cnt_nx;
      sp_q     <= sp_nx;
      irq_q    <= irq_nx;
      spmode_q <= spmode;
    end
  end

  // Next-state and datapath decisions for both transfer directions
  always_comb begin
    state_nx   = state;
    sdr_reg_nx = sdr_reg;
    shifter_nx = shifter;
    bitcnt_nx  = bitcnt;
    pending_nx = pending;
    cnt_nx     = cnt_q;
    sp_nx      = sp_q;
    irq_nx     = 1'b0;

    // CPU write first so that an input-mode completion below overrides it
    if (sdr_write) begin
      sdr_reg_nx = data_in;
    end

    if (mode_change) begin
      // Direction flip abandons any partial byte but keeps the register
      state_nx   = IDLE;
      shifter_nx = '0;
      bitcnt_nx  = '0;
      pending_nx = 1'b0;
      cnt_nx     = 1'b1;
      sp_nx      = 1'b1;
    end else if (spmode) begin
      case (state)
        IDLE: begin
          cnt_nx = 1'b1;
          if (tmra_ovf && pending) begin
            shifter_nx = sdr_reg;
            pending_nx = 1'b0;
            bitcnt_nx  = '0;
            cnt_nx     = 1'b0;
            sp_nx      = sdr_reg[BITS-1];
            state_nx   = SHIFT;
          end
        end
        SHIFT: begin
          if (tmra_ovf) begin
            if (!cnt_q) begin
              // CNT rising: a bit has been presented for a full half period
              cnt_nx = 1'b1;
              if (bitcnt == LAST_BIT) begin
                irq_nx    = 1'b1;
                bitcnt_nx = '0;
                if (pending) begin
                  // Back-to-back byte: next underflow drives the new MSB
                  shifter_nx = sdr_reg;
                  pending_nx = 1'b0;
                end else begin
                  state_nx = IDLE;
                end
              end else begin
                bitcnt_nx  = bitcnt + CW'(1);
                shifter_nx = shifter << 1;
              end
            end else begin
              // CNT falling: present the next bit on SP
              cnt_nx = 1'b0;
              sp_nx  = shifter[BITS-1];
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end else begin
      state_nx   = IDLE;
      pending_nx = 1'b0;
      cnt_nx     = 1'b1;
      sp_nx      = 1'b1;
      if (cnt_rise) begin
        shifter_nx = shifted_in;
        if (bitcnt == LAST_BIT) begin
          sdr_reg_nx = shifted_in;
          irq_nx     = 1'b1;
          bitcnt_nx  = '0;
        end else begin
          bitcnt_nx = bitcnt + CW'(1);
        end
      end
    end

    // A write only queues a transmission when the direction is stable output
    if (sdr_write && spmode && !mode_change) begin
      pending_nx = 1'b1;
    end
  end

  assign data_out = (~wr & sdr) ? sdr_reg : '0;
  assign cnt_out  = cnt_q;
  assign sp_out   = sp_q;
  assign irq      = irq_q;

endmodule : cia_serialport
`default_nettype wire

// File: tb/tb_cia_serialport.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_cia_serialport
// Description : Self-checking bench for cia_serialport: register access
//               vectors, output-mode streams, input-mode capture, mode change
//               and reset mid-transfer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_cia_serialport;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk7_en = 1'b1;
  logic       wr = 1'b0;
  logic       sdr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tmra_ovf = 1'b0;
  logic       spmode = 1'b0;
  logic       cnt_in = 1'b1;
  logic       sp_in = 1'b1;
  logic       cnt_out;
  logic       sp_out;
  logic       irq;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  typedef struct {
    logic       wr;
    logic       sdr;
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [7];

  cia_serialport #(
    .BITS        (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk7_en  (clk7_en),
    .wr       (wr),
    .sdr      (sdr),
    .data_in  (data_in),
    .data_out (data_out),
    .tmra_ovf (tmra_ovf),
    .spmode   (spmode),
    .cnt_in   (cnt_in),
    .sp_in    (sp_in),
    .cnt_out  (cnt_out),
    .sp_out   (sp_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (irq) irq_cnt++;
  endtask

  task automatic pulse();
    tmra_ovf = 1'b1;
    step();
    tmra_ovf = 1'b0;
  endtask

  task automatic write_sdr(input logic [7:0] d);
    wr = 1'b1; sdr = 1'b1; data_in = d;
    step();
    wr = 1'b0; sdr = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] exp);
    sdr = 1'b1;
    #1;
    check(name, data_out, exp);
    sdr = 1'b0;
  endtask

  initial begin
    logic [7:0]  pat;
    logic [15:0] pair;
    logic [15:0] stream;
    logic [7:0]  ibits;
    int          base;

    // Register access vectors, input mode so writes queue nothing
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h5A, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hA5};
    vecs[5] = '{1'b1, 1'b1, 8'h3C, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h3C};

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    step();
    read_check("reset_sdr", 8'h00);
    check("reset_cnt_out", cnt_out, 1);
    check("reset_sp_out", sp_out, 1);
    check("reset_irq", irq, 0);

    for (int i = 0; i < 7; i++) begin
      wr = vecs[i].wr; sdr = vecs[i].sdr; data_in = vecs[i].din;
      #1;
      check($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_dout);
      step();
    end
    wr = 1'b0; sdr = 1'b0;

    // Output mode single byte A5
    spmode = 1'b1;
    repeat (2) step();
    irq_cnt = 0;
    pat = 8'hA5;
    write_sdr(pat);
    for (int k = 1; k <= 16; k++) begin
      pulse();
      if (k % 2 == 1) begin
        check($sformatf("a5_cnt_low_p%0d", k), cnt_out, 0);
        check($sformatf("a5_sp_p%0d", k), sp_out, pat[7 - (k - 1) / 2]);
      end else begin
        check($sformatf("a5_cnt_high_p%0d", k), cnt_out, 1);
      end
      check($sformatf("a5_irq_p%0d", k), irq, (k == 16) ? 1 : 0);
      step();
    end
    check("a5_irq_one_cycle", irq, 0);
    check("a5_irq_count", irq_cnt, 1);
    pulse();
    check("a5_idle_cnt_out", cnt_out, 1);
    step();

    // Output mode back-to-back 3C then C3
    irq_cnt = 0;
    pair = 16'h3CC3;
    stream = 16'h0000;
    write_sdr(8'h3C);
    for (int k = 1; k <= 32; k++) begin
      pulse();
      if (k % 2 == 1) begin
        stream = {stream[14:0], sp_out};
        check($sformatf("b2b_cnt_low_p%0d", k), cnt_out, 0);
      end
      check($sformatf("b2b_irq_p%0d", k), irq, (k == 16 || k == 32) ? 1 : 0);
      step();
      if (k == 5) write_sdr(8'hC3);
    end
    check("b2b_stream", stream, pair);
    check("b2b_irq_count", irq_cnt, 2);
    check("b2b_cnt_out_end", cnt_out, 1);

    // Input mode capture of 8'h69
    spmode = 1'b0;
    repeat (3) step();
    irq_cnt = 0;
    ibits = 8'h69;
    for (int b = 7; b >= 0; b--) begin
      cnt_in = 1'b0; sp_in = ibits[b];
      repeat (3) step();
      cnt_in = 1'b1;
      step();
      step();
      if (b == 0) check("in_irq_before_latency", irq, 0);
      step();
      if (b == 0) check("in_irq_after_latency", irq, 1);
    end
    step();
    check("in_irq_one_cycle", irq, 0);
    check("in_irq_count", irq_cnt, 1);
    check("in_cnt_out", cnt_out, 1);
    check("in_sp_out", sp_out, 1);
    read_check("in_sdr_69", 8'h69);
    sp_in = 1'b1;

    // Mode change mid-transfer
    spmode = 1'b1;
    repeat (2) step();
    irq_cnt = 0;
    write_sdr(8'hFF);
    for (int k = 1; k <= 6; k++) begin
      pulse();
      step();
    end
    check("mc_bitcnt_before", dut.bitcnt, 3);
    spmode = 1'b0;
    repeat (3) step();
    check("mc_irq_count", irq_cnt, 0);
    check("mc_cnt_out", cnt_out, 1);
    check("mc_sp_out", sp_out, 1);
    check("mc_bitcnt", dut.bitcnt, 0);
    read_check("mc_sdr_ff", 8'hFF);

    // Output mode without a pending byte
    spmode = 1'b1;
    repeat (2) step();
    irq_cnt = 0;
    base = 0;
    for (int k = 1; k <= 20; k++) begin
      pulse();
      if (cnt_out !== 1'b1) base++;
      step();
    end
    check("nopend_cnt_low_seen", base, 0);
    check("nopend_irq_count", irq_cnt, 0);

    // Reset in the middle of a transfer
    irq_cnt = 0;
    write_sdr(8'h5A);
    for (int k = 1; k <= 3; k++) begin
      pulse();
      step();
    end
    check("rst_mid_cnt_low", cnt_out, 0);
    reset = 1'b1;
    step();
    check("rst_mid_cnt_out", cnt_out, 1);
    check("rst_mid_sp_out", sp_out, 1);
    check("rst_mid_bitcnt", dut.bitcnt, 0);
    reset = 1'b0;
    step();
    read_check("rst_mid_sdr", 8'h00);
    check("rst_mid_irq_count", irq_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cia_serialport
`default_nettype wire

// File: doc/cia_serialport.md
Name: cia_serialport

Overview:
CIA serial data register (SDR, register $xC) and 8-bit shifter, directly downstream of Timer A.
- Consumes Timer A's `tmra_ovf` (underflow pulse) as the output-mode baud source.
- Consumes Timer A's `spmode` (CRA bit 6) as the direction select.
- Drives the CNT/SP pins in output mode and samples them in input mode.
- Raises the serial-port interrupt source to the ICR block after each completed byte.

Parameters:
- BITS, 8, shifter length and bit count per transfer
- SYNC_STAGES, 2, synchroniser depth on `cnt_in` and `sp_in`

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- clk7_en  in  1  7 MHz enable; all state updates are qualified by it
- wr  in  1  CPU write strobe
- sdr  in  1  SDR register select ($xC) from address decoder
- data_in  in  8  CPU write data
- data_out  out  8  CPU read data; 0 when not selected
- tmra_ovf  in  1  Timer A underflow pulse, one clk7_en cycle wide
- spmode  in  1  0 = input, 1 = output
- cnt_in  in  1  CNT pin input (async)
- sp_in  in  1  SP pin input (async)
- cnt_out  out  1  CNT pin drive in output mode
- sp_out  out  1  SP pin drive in output mode
- irq  out  1  serial interrupt pulse, one clk7_en cycle

Behaviour:
Reset values:
- `sdr_reg` = 0, `shifter` = 0, `bitcnt` = 0, `pending` = 0
- `cnt_out` = 1, `sp_out` = 1, `irq` = 0, state = IDLE

Register access:
- `data_out` = `sdr_reg` when `~wr & sdr`, else 0.
- A write to SDR loads `sdr_reg` <= `data_in` and, only when `spmode` = 1, sets `pending`.
- A write while `pending` is already 1 overwrites `sdr_reg`; last write wins.

Output mode (`spmode` = 1), states IDLE / SHIFT:
- IDLE: `cnt_out` = 1. When `tmra_ovf` arrives with `pending` = 1:
  - `shifter` <= `sdr_reg`, `pending` <= 0, `bitcnt` <= 0
  - `cnt_out` <= 0, `sp_out` <= `sdr_reg[7]`, go to SHIFT
  - A `tmra_ovf` while `pending` = 0 is ignored.
- SHIFT: every `tmra_ovf` toggles `cnt_out`.
  - On 0->1 (CNT rising): `bitcnt` += 1 and `shifter` <= `shifter << 1`.
  - On 1->0 (CNT falling): `sp_out` <= `shifter[7]`.
- Rising edge that makes `bitcnt` = BITS (16th underflow after start):
  - `irq` pulses high for that cycle.
  - If `pending` = 1 in that same cycle: reload `shifter` from `sdr_reg`, clear `pending`, `bitcnt` <= 0, stay in SHIFT. The next underflow drives CNT low with the new MSB (back-to-back bytes, no gap).
  - Otherwise: go to IDLE with `cnt_out` = 1; `sp_out` holds the last bit.
- Bit order: MSB first. One byte occupies exactly 16 `tmra_ovf` pulses.

Input mode (`spmode` = 0):
- `cnt_in` and `sp_in` pass through SYNC_STAGES flops. Edge detection is done on synchronised `cnt` against its previous value.
- On synchronised CNT rising edge: `shifter` <= {`shifter[6:0]`, `sp_sync`}, `bitcnt` += 1.
- When `bitcnt` reaches BITS: `sdr_reg` <= shifted value (including the bit just sampled), `irq` pulse, `bitcnt` <= 0.
- `tmra_ovf` is ignored. `cnt_out` = 1 and `sp_out` = 1.
- A CPU write to `sdr_reg` in the same cycle as a byte completion loses to the completion.

Mode change:
- Any change of `spmode` (registered compare) clears `bitcnt` and `pending` and forces IDLE.
- It also sets `cnt_out` = 1 and `sp_out` = 1 and drops the partial byte. `sdr_reg` is preserved.

Other rules:
- Reset mid-transfer returns everything to reset values on the next qualified edge. No `irq` is generated.
- `irq` is registered. It never stays high for more than one clk7_en cycle.

Decomposition:
- Package `cia_pkg`:
  - SDR_BITS = 8
  - CRA bit indices (START = 0, RUNMODE = 3, LOAD = 4, SPMODE = 6)
  - State enum {IDLE, SHIFT}
  - Register offset constants ($4, $5, $C, $E)
- Sub-module `cia_pin_sync`: parameterised multi-stage synchroniser plus rising-edge detector, one instance per pin (CNT, SP); the SP instance's edge output is unused.

Test Plan:
- Reset, then read SDR -> `data_out` = 8'h00, `cnt_out` = 1, `sp_out` = 1, `irq` = 0.
- `spmode` = 1, write 8'hA5, then 16 `tmra_ovf` pulses -> `sp_out` sequence at CNT falls = 1,0,1,0,0,1,0,1; `irq` pulse coincident with the 16th pulse; `cnt_out` = 1 afterwards.
- `spmode` = 1:
  - Write 8'h3C.
  - After the 5th `tmra_ovf`, write 8'hC3.
  - Run 32 pulses.
  - Expect two `irq` pulses (at pulses 16 and 32) and the serial stream 3C then C3 with no idle pulse between.
- `spmode` = 0, drive 8 CNT rising edges with SP = 0,1,1,0,1,0,0,1 -> read SDR = 8'h69 with exactly one `irq` pulse, issued after the sync latency.
- `spmode` = 1, write 8'hFF, toggle `spmode` to 0 after 6 underflows -> no `irq`, `cnt_out` = 1, `sp_out` = 1, SDR reads 8'hFF, `bitcnt` = 0.
- `spmode` = 1 with no SDR write, 20 `tmra_ovf` pulses -> `cnt_out` stays 1, no `irq`.
